reversible_nibble_subtractor: RTL and testbench
===============================================

# reversible_nibble_subtractor

Multi-cycle reversible-logic subtractor for the MAC8 datapath: the inverse of the accumulator's adder. It takes an adder result {carry, sum} and the addend B with carry-in, and reconstructs operand A = sum − B − cin. One 4-bit nibble is processed per cycle using a ripple of reversible full subtractors. It sits behind the MAC8 accumulator, where it un-computes partial sums and checks adder consistency, with valid/ready handshakes on both sides.

## Interface
- WIDTH, default 8: operand width in bits; must be a multiple of 4 and at least 4.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- sum_i  input  WIDTH  adder sum (minuend).
- b_i  input  WIDTH  adder operand B (subtrahend).
- cin_i  input  1  adder carry-in (borrow-in).
- carry_i  input  1  adder carry-out, used only for the consistency check.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- a_o  output  WIDTH  reconstructed operand A.
- borrow_o  output  1  final borrow.
- mismatch_o  output  1  consistency flag (see Configuration).

## Operation
- Arithmetic: a_o = (sum_i − b_i − cin_i) mod 2^WIDTH.
- borrow_o = 1 iff sum_i < b_i + cin_i, computed at full precision.
- For a consistent adder result, borrow_o equals carry_i.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: capture sum_i, b_i, cin_i and carry_i into registers; clear the nibble index; load the borrow register with cin_i; go to RUN.
  - Inputs are ignored in every other state.
- RUN:
  - Each cycle processes nibble[idx], LSB nibble first, through four chained reversible full subtractors.
  - The 4 result bits are written into the a_o register; the nibble borrow-out goes to the borrow register; idx increments.
  - On the cycle that processes the last nibble (idx = WIDTH/4 − 1): go to DONE; borrow_o and mismatch_o update on that same edge.
- DONE:
  - out_valid = 1; a_o, borrow_o and mismatch_o are held stable.
  - On out_ready: go to IDLE.
- Index wrap: idx never exceeds WIDTH/4 − 1. It clears on acceptance.
- Reset values: state IDLE, in_ready 1, out_valid 0, a_o 0, borrow_o 0, mismatch_o 0, idx 0.

## Timing
- Request accepted at edge k; out_valid is high from edge k + WIDTH/4. For WIDTH = 8 this is 2 cycles.
- in_ready is combinational from state (IDLE only). in_valid does not combinationally affect any output.
- Output handshake completes at edge m, where out_valid && out_ready. in_ready is high from edge m.
- Minimum request-to-request spacing: WIDTH/4 + 2 cycles.
- out_ready held low: DONE persists indefinitely and outputs are held.
- out_ready already high when DONE is entered: completes on the first DONE cycle.
- rst_n asserted mid-RUN or in DONE: immediate return to the reset values. The partial result is discarded and no out_valid pulse is produced.
- Reset deassertion is synchronized externally; the block needs no internal synchronizer.

## Configuration
- Macro RNS_CONSISTENCY_CHECK_EN.
- Defined: mismatch_o = (final borrow != captured carry_i). It updates and is held with a_o.
- Undefined: mismatch_o is tied to 0, the carry_i capture register is omitted, and carry_i is unused.
- Port list is identical in both builds.

## Structure
- Shared package rev_pkg holds:
  - NIBBLE = 4.
  - The FSM state typedef (IDLE, RUN, DONE).
  - A function returning WIDTH/4 for the index range.
- Sub-module reversible_full_subtractor:
  - Peres/Toffoli-based single-bit subtractor.
  - Ports a, b, bin, ancilla (tied 0) in; diff, bout out.
  - Instantiated 4× per nibble slice.

## Test plan
- WIDTH=8, sum=0x5A, b=0x23, cin=0 → a_o=0x37, borrow_o=0, out_valid exactly 2 cycles after acceptance.
- sum=0x10, b=0x20, cin=1 → a_o=0xEF, borrow_o=1.
- Wrap case: sum=0x00, b=0xFF, cin=1, carry=1 → a_o=0x00, borrow_o=1, mismatch_o=0.
- sum=0x5A, b=0x23, cin=0, carry=1 → mismatch_o=1 with RNS_CONSISTENCY_CHECK_EN defined, 0 without.
- Backpressure: out_ready low for 5 cycles → a_o and out_valid held, in_ready=0, and new in_valid is ignored. Raising out_ready gives in_ready=1 on the next cycle.
- rst_n pulsed low during RUN → all outputs return to reset values. A following request (sum=0xFF, b=0x01, cin=0) yields a_o=0xFE, borrow_o=0.

Source files
------------

// File: rtl/rev_pkg.sv
// Shared definitions for the reversible nibble subtractor: the nibble size,
// the FSM state encoding and the nibble-count helper used to size the index.
package rev_pkg;

   // Bits handled per RUN cycle; one reversible full subtractor per bit.
   localparam int unsigned NIBBLE = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } rns_state_e;

   // Number of nibbles in an operand of the given width (index range).
   function automatic int unsigned num_nibbles(input int unsigned width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/reversible_full_subtractor.sv
// Single-bit reversible full subtractor built from two Peres gates.
//   diff = a ^ b ^ bin
//   bout = (~a & b) | (~(a ^ b) & bin)
// The two product terms are mutually exclusive, so the Toffoli XOR in the
// second Peres gate accumulates them into the ancilla as a plain OR.
// The ancilla input must be tied to 0; garbage outputs are not exposed.
module reversible_full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   input  logic ancilla,
   output logic diff,
   output logic bout
);

   logic a_n;       // NOT gate on a
   logic p1_xor;    // Peres #1 target:  ~a ^ b = ~(a ^ b)
   logic p1_and;    // Peres #1 ancilla: ancilla ^ (~a & b)
   logic p2_xor;    // Peres #2 target:  ~(a ^ b) ^ bin = ~diff

   // Gate cascade: NOT, Peres(a_n, b, ancilla), Peres(p1_xor, bin, p1_and), NOT.
   always_comb begin
      a_n    = ~a;
      p1_xor = a_n ^ b;
      p1_and = ancilla ^ (a_n & b);
      p2_xor = p1_xor ^ bin;
      bout   = p1_and ^ (p1_xor & bin);
      diff   = ~p2_xor;
   end

endmodule

// File: rtl/reversible_nibble_subtractor.sv
// Multi-cycle reversible subtractor: reconstructs A = sum - b - cin from an
// adder result, one nibble per cycle, LSB nibble first, with valid/ready on
// both sides. Optional feature macro RNS_CONSISTENCY_CHECK_EN enables the
// mismatch_o check of the final borrow against the captured adder carry-out;
// without it mismatch_o is 0 and carry_i is unused.
module reversible_nibble_subtractor
   import rev_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] sum_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   input  logic             carry_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] a_o,
   output logic             borrow_o,
   output logic             mismatch_o
);

   localparam int unsigned     NumNib  = num_nibbles(WIDTH);
   localparam int unsigned     IdxW    = (NumNib > 1) ? $clog2(NumNib) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumNib - 1);

   rns_state_e       state_q, state_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             borrow_q, borrow_d;    // running borrow between nibbles
   logic [WIDTH-1:0] a_q, a_d;
   logic             bout_q, bout_d;        // final borrow, held for borrow_o

   logic [NIBBLE-1:0] min_nib;
   logic [NIBBLE-1:0] sub_nib;
   logic [NIBBLE-1:0] diff_nib;
   logic [NIBBLE:0]   chain;

`ifdef RNS_CONSISTENCY_CHECK_EN
   logic carry_q, carry_d;
   logic mism_q, mism_d;
`else
   logic unused_carry;
   assign unused_carry = carry_i;
`endif

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign a_o       = a_q;
   assign borrow_o  = bout_q;

`ifdef RNS_CONSISTENCY_CHECK_EN
   assign mismatch_o = mism_q;
`else
   assign mismatch_o = 1'b0;
`endif

   // Select the nibble pair addressed by the current index.
   always_comb begin
      min_nib = '0;
      sub_nib = '0;
      for (int unsigned n = 0; n < NumNib; n++) begin
         if (idx_q == IdxW'(n)) begin
            min_nib = sum_q[n*NIBBLE +: NIBBLE];
            sub_nib = b_q[n*NIBBLE +: NIBBLE];
         end
      end
   end

   // Borrow ripples through four reversible full subtractors per cycle.
   assign chain[0] = borrow_q;

   for (genvar i = 0; i < NIBBLE; i++) begin : g_slice
      reversible_full_subtractor u_rfs (
         .a       (min_nib[i]),
         .b       (sub_nib[i]),
         .bin     (chain[i]),
         .ancilla (1'b0),
         .diff    (diff_nib[i]),
         .bout    (chain[i+1])
      );
   end

   // Next-state logic: capture in IDLE, one nibble per RUN cycle, hold in DONE.
   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      b_d      = b_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      bout_d   = bout_q;
`ifdef RNS_CONSISTENCY_CHECK_EN
      carry_d  = carry_q;
      mism_d   = mism_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sum_d    = sum_i;
               b_d      = b_i;
               borrow_d = cin_i;
               idx_d    = '0;
`ifdef RNS_CONSISTENCY_CHECK_EN
               carry_d  = carry_i;
`endif
               state_d  = StRun;
            end
         end

         StRun: begin
            for (int unsigned n = 0; n < NumNib; n++) begin
               if (idx_q == IdxW'(n)) begin
                  a_d[n*NIBBLE +: NIBBLE] = diff_nib;
               end
            end
            borrow_d = chain[NIBBLE];
            if (idx_q == LastIdx) begin
               // Index stays at the last nibble; it is cleared on the next acceptance.
               bout_d  = chain[NIBBLE];
`ifdef RNS_CONSISTENCY_CHECK_EN
               mism_d  = (chain[NIBBLE] != carry_q);
`endif
               state_d = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end

         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sum_q    <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sum_q    <= sum_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         bout_q   <= bout_d;
      end
   end

`ifdef RNS_CONSISTENCY_CHECK_EN
   // Consistency-check registers: captured carry-out and the resulting flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
         mism_q  <= 1'b0;
      end else begin
         carry_q <= carry_d;
         mism_q  <= mism_d;
      end
   end
`endif

endmodule

// File: tb/tb_reversible_nibble_subtractor.sv
// Directed bench for reversible_nibble_subtractor (WIDTH = 8). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_reversible_nibble_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum_i;
   logic [W-1:0] b_i;
   logic         cin_i;
   logic         carry_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] a_o;
   logic         borrow_o;
   logic         mismatch_o;

   int checks = 0;
   int errors = 0;

   reversible_nibble_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .sum_i      (sum_i),
      .b_i        (b_i),
      .cin_i      (cin_i),
      .carry_i    (carry_i),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .a_o        (a_o),
      .borrow_o   (borrow_o),
      .mismatch_o (mismatch_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge and check the 2-cycle latency to out_valid.
   task automatic request(input logic [7:0] s, input logic [7:0] b, input logic c,
                          input logic cy, input string tag);
      @(negedge clk);
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      sum_i    = s;
      b_i      = b;
      cin_i    = c;
      carry_i  = cy;
      in_valid = 1'b1;
      @(posedge clk);          // acceptance edge k
      #1 in_valid = 1'b0;
      sum_i = 8'hCC;
      b_i   = 8'h33;
      @(negedge clk);
      chk({tag, ".run_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, ".valid_k0"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);          // after k+1
      chk({tag, ".valid_k1"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);          // after k+2
      chk({tag, ".valid_k2"}, {31'd0, out_valid}, 32'd1);
   endtask

   // Complete the output handshake and check the return to IDLE.
   task automatic drain(input string tag);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      sum_i     = '0;
      b_i       = '0;
      cin_i     = 1'b0;
      carry_i   = 1'b0;

      // Reset values
      #12;
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.a_o", {24'd0, a_o}, 32'h00);
      chk("rst.borrow", {31'd0, borrow_o}, 32'd0);
      chk("rst.mismatch", {31'd0, mismatch_o}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 0x5A - 0x23 - 0 = 0x37, no borrow, consistent with carry 0
      request(8'h5A, 8'h23, 1'b0, 1'b0, "t1");
      chk("t1.a_o", {24'd0, a_o}, 32'h37);
      chk("t1.borrow", {31'd0, borrow_o}, 32'd0);
      chk("t1.mismatch", {31'd0, mismatch_o}, 32'd0);
      drain("t1");

      // 0x10 - 0x20 - 1 = 0xEF with borrow; out_ready already high on DONE entry
      out_ready = 1'b1;
      request(8'h10, 8'h20, 1'b1, 1'b1, "t2");
      chk("t2.a_o", {24'd0, a_o}, 32'hEF);
      chk("t2.borrow", {31'd0, borrow_o}, 32'd1);
      @(negedge clk);
      chk("t2.one_cycle_valid", {31'd0, out_valid}, 32'd0);
      chk("t2.back_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;

      // Wrap: 0x00 - 0xFF - 1 = 0x00 with borrow, carry 1 is consistent
      request(8'h00, 8'hFF, 1'b1, 1'b1, "t3");
      chk("t3.a_o", {24'd0, a_o}, 32'h00);
      chk("t3.borrow", {31'd0, borrow_o}, 32'd1);
      chk("t3.mismatch", {31'd0, mismatch_o}, 32'd0);
      drain("t3");

      // Inconsistent carry: flagged only when the check is built in
      request(8'h5A, 8'h23, 1'b0, 1'b1, "t4");
      chk("t4.a_o", {24'd0, a_o}, 32'h37);
      chk("t4.borrow", {31'd0, borrow_o}, 32'd0);
`ifdef RNS_CONSISTENCY_CHECK_EN
      chk("t4.mismatch", {31'd0, mismatch_o}, 32'd1);
`else
      chk("t4.mismatch", {31'd0, mismatch_o}, 32'd0);
`endif

      // Backpressure: hold DONE 5 cycles while a new request is offered
      #1 in_valid = 1'b1;
      sum_i = 8'h99;
      b_i   = 8'h11;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp.a_o", {24'd0, a_o}, 32'h37);
      end
      in_valid = 1'b0;
      drain("bp");
      // The request offered during DONE must not have started a new operation
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp.no_ghost", {31'd0, out_valid}, 32'd0);
      end

      // Reset pulsed during RUN
      @(negedge clk);
      sum_i    = 8'h5A;
      b_i      = 8'h23;
      cin_i    = 1'b0;
      carry_i  = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rr.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rr.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rr.a_o", {24'd0, a_o}, 32'h00);
      chk("rr.borrow", {31'd0, borrow_o}, 32'd0);
      chk("rr.mismatch", {31'd0, mismatch_o}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr.no_valid", {31'd0, out_valid}, 32'd0);
      end

      // 0xFF - 0x01 - 0 = 0xFE after reset
      request(8'hFF, 8'h01, 1'b0, 1'b0, "t6");
      chk("t6.a_o", {24'd0, a_o}, 32'hFE);
      chk("t6.borrow", {31'd0, borrow_o}, 32'd0);
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
